// File: rtl/icache_line_fill.sv
// Line-fill engine for the 32x256 icache data macro: fetches a line as sequential beats,
// writes it with a full mask, follows with a dummy read, and forwards lookups while idle.
module icache_line_fill #(
   parameter int ADDR_WIDTH = 32,
   parameter int SET_BITS   = 5,
   parameter int LINE_WIDTH = 256,
   parameter int BEAT_WIDTH = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    fill_req,
   input  logic [ADDR_WIDTH-1:0]   fill_addr,
   input  logic [SET_BITS-1:0]     fill_set,
   output logic                    fill_busy,
   output logic                    fill_done,
   output logic [LINE_WIDTH-1:0]   fill_line,
   input  logic                    lkp_csb,
   input  logic [SET_BITS-1:0]     lkp_addr,
   output logic                    mem_read,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   input  logic                    mem_ready,
   input  logic                    mem_rvalid,
   input  logic [BEAT_WIDTH-1:0]   mem_rdata,
   output logic                    sram_csb0,
   output logic                    sram_web0,
   output logic [LINE_WIDTH/8-1:0] sram_wmask0,
   output logic [SET_BITS-1:0]     sram_addr0,
   output logic [LINE_WIDTH-1:0]   sram_din0
);

   localparam int BEATS  = LINE_WIDTH / BEAT_WIDTH;
   localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int OFF_W  = $clog2(LINE_WIDTH / 8);
   localparam int MASK_W = LINE_WIDTH / 8;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_BURST = 3'd2,
      S_WRITE = 3'd3,
      S_FLUSH = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t                  state_r;
   state_t                  state_s;
   logic [CNT_W-1:0]        beat_r;
   logic [ADDR_WIDTH-1:0]   addr_r;
   logic [SET_BITS-1:0]     set_r;
   logic [LINE_WIDTH-1:0]   line_r;
   logic                    mem_read_r;
   logic                    fill_busy_r;
   logic                    fill_done_r;
   logic                    unused_s;

   // Byte-offset bits of the miss address never reach memory.
   assign unused_s = ^fill_addr[OFF_W-1:0];

   // State register, request capture, beat assembly and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= S_IDLE;
         beat_r      <= {CNT_W{1'b0}};
         addr_r      <= {ADDR_WIDTH{1'b0}};
         set_r       <= {SET_BITS{1'b0}};
         line_r      <= {LINE_WIDTH{1'b0}};
         mem_read_r  <= 1'b0;
         fill_busy_r <= 1'b0;
         fill_done_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         mem_read_r  <= (state_s == S_REQ);
         fill_busy_r <= (state_s != S_IDLE);
         fill_done_r <= (state_s == S_DONE);
         case (state_r)
            S_IDLE: begin
               if (fill_req) begin
                  addr_r <= {fill_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                  set_r  <= fill_set;
                  beat_r <= {CNT_W{1'b0}};
               end
            end
            S_BURST: begin
               if (mem_rvalid) begin
                  for (int k = 0; k < BEATS; k++) begin
                     if (beat_r == CNT_W'(k)) begin
                        line_r[k*BEAT_WIDTH +: BEAT_WIDTH] <= mem_rdata;
                     end
                  end
                  beat_r <= beat_r + CNT_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Next-state logic; the last beat in BURST moves straight to the macro write.
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (fill_req) state_s = S_REQ;
            else          state_s = S_IDLE;
         end
         S_REQ: begin
            if (mem_ready) state_s = S_BURST;
            else           state_s = S_REQ;
         end
         S_BURST: begin
            if (mem_rvalid && (beat_r == CNT_W'(BEATS - 1))) state_s = S_WRITE;
            else                                              state_s = S_BURST;
         end
         S_WRITE: state_s = S_FLUSH;
         S_FLUSH: state_s = S_DONE;
         S_DONE:  state_s = S_IDLE;
         default: state_s = S_IDLE;
      endcase
   end

   // Macro port mux: lookups pass through only in IDLE; the macro registers these itself.
   always_comb begin
      sram_csb0   = 1'b1;
      sram_web0   = 1'b1;
      sram_wmask0 = {MASK_W{1'b0}};
      sram_addr0  = set_r;
      sram_din0   = line_r;
      if (rst) begin
         sram_csb0 = 1'b1;
      end else begin
         case (state_r)
            S_IDLE: begin
               sram_csb0  = lkp_csb;
               sram_addr0 = lkp_addr;
            end
            S_WRITE: begin
               sram_csb0   = 1'b0;
               sram_web0   = 1'b0;
               sram_wmask0 = {MASK_W{1'b1}};
            end
            // Dummy read clears the macro's latched write enable.
            S_FLUSH: begin
               sram_csb0 = 1'b0;
            end
            default: begin
               sram_csb0 = 1'b1;
            end
         endcase
      end
   end

   assign mem_read  = mem_read_r;
   assign mem_addr  = addr_r;
   assign fill_busy = fill_busy_r;
   assign fill_done = fill_done_r;
   assign fill_line = line_r;

endmodule
